// File: rtl/sr_icache_pkg.sv
// sr_icache shared definitions: FSM encodings, parameter defaults and the
// array write-control bundle.
package sr_icache_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOOKUP = 2'd1;
  localparam logic [1:0] S_REFILL = 2'd2;

  localparam int ADDR_W_DEF     = 30;
  localparam int LINES_DEF      = 16;
  localparam int LINE_WORDS_DEF = 4;
  localparam int WORD_W         = 32;

  // Write-side controls for the line storage.
  typedef struct packed {
    logic word_en;    // store one refill word
    logic tag_en;     // store the tag (final refill word)
    logic set_valid;  // mark the line valid together with the tag
    logic clr;        // drop every valid bit
  } arr_ctl_t;

endpackage

// File: rtl/sr_icache_if.sv
// Fetch-side and backing-memory-side bundles for sr_icache.

// CPU fetch port: the CPU is master, the cache is slave.
interface sr_icache_if;
  import sr_icache_pkg::*;
  logic              im_req;
  logic [31:0]       im_addr;
  logic [WORD_W-1:0] im_data;
  logic              im_drdy;

  modport master (output im_req, im_addr, input  im_data, im_drdy);
  modport slave  (input  im_req, im_addr, output im_data, im_drdy);
endinterface

// Backing memory port: the cache is master, the memory is slave.
interface sr_mem_if #(parameter int ADDR_W = 30);
  import sr_icache_pkg::*;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (output mem_req, mem_addr, input  mem_rdata, mem_ack);
  modport slave  (input  mem_req, mem_addr, output mem_rdata, mem_ack);
endinterface

// File: rtl/sr_icache_array.sv
// Line storage: valid bits, tags and data words in flops, read
// combinationally at (idx_i, rd_off_i). Writes always target idx_i.
module sr_icache_array
  import sr_icache_pkg::*;
#(
  parameter  int LINES      = LINES_DEF,
  parameter  int LINE_WORDS = LINE_WORDS_DEF,
  parameter  int TAG_W      = 24,
  localparam int IDX_W      = $clog2(LINES),
  localparam int OFF_W      = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [OFF_W-1:0]  rd_off_i,
  input  logic [OFF_W-1:0]  wr_off_i,
  input  arr_ctl_t          ctl_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [WORD_W-1:0] wr_data_i,
  output logic              valid_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic [WORD_W-1:0] data_o
);

  logic [LINES-1:0]                             valid_q;
  logic [LINES-1:0][TAG_W-1:0]                  tag_q;
  logic [LINES-1:0][LINE_WORDS-1:0][WORD_W-1:0] data_q;

  assign valid_o = valid_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign data_o  = data_q[idx_i][rd_off_i];

  // Valid bits: a clear wins over a set landing on the same edge, so a
  // line finishing refill while invalidated stays invalid.
  always_ff @(posedge clk) begin
    if (rst || ctl_i.clr)
      valid_q <= '0;
    else if (ctl_i.tag_en && ctl_i.set_valid)
      valid_q[idx_i] <= 1'b1;
  end

  // Tag and data payload need no reset; validity guards them.
  always_ff @(posedge clk) begin
    if (ctl_i.tag_en)  tag_q[idx_i]            <= wr_tag_i;
    if (ctl_i.word_en) data_q[idx_i][wr_off_i] <= wr_data_i;
  end

endmodule

// File: rtl/sr_icache.sv
// Direct-mapped read-only instruction cache on the schoolRISCV fetch port.
// Hits answer in the LOOKUP cycle; misses refill the whole line in order
// offset 0..LINE_WORDS-1, one outstanding memory read at a time.
module sr_icache
  import sr_icache_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int LINES      = LINES_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inv_i,
  sr_icache_if.slave fe,
  sr_mem_if.master   mem
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam logic [OFF_W-1:0] LAST = OFF_W'(LINE_WORDS - 1);

  logic [1:0]        state_q,    state_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [OFF_W-1:0]  cnt_q,      cnt_d;
  logic              inv_pend_q, inv_pend_d;

  logic [OFF_W-1:0]  off;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              line_valid;
  logic [TAG_W-1:0]  line_tag;
  logic [WORD_W-1:0] line_data;
  logic              hit;
  logic              refill_ack;
  arr_ctl_t          ctl;

  assign off = req_addr_q[OFF_W-1:0];
  assign idx = req_addr_q[OFF_W +: IDX_W];
  assign tag = req_addr_q[ADDR_W-1 -: TAG_W];

  // Word-address bits above ADDR_W are not part of the cache address.
  generate
    if (ADDR_W < 32) begin : g_unused_addr
      logic unused_addr_hi;
      assign unused_addr_hi = ^fe.im_addr[31:ADDR_W];
    end
  endgenerate

  assign hit        = line_valid && (line_tag == tag);
  assign refill_ack = (state_q == S_REFILL) && mem.mem_ack;

  assign fe.im_drdy   = (state_q == S_LOOKUP) && hit;
  assign fe.im_data   = line_data;
  assign mem.mem_req  = (state_q == S_REFILL);
  assign mem.mem_addr = (state_q == S_REFILL) ? {tag, idx, cnt_q} : '0;

  always_comb begin
    ctl           = '0;
    ctl.word_en   = refill_ack;
    ctl.tag_en    = refill_ack && (cnt_q == LAST);
    ctl.set_valid = !inv_pend_q;
    ctl.clr       = inv_i;
  end

  sr_icache_array #(
    .LINES      (LINES),
    .LINE_WORDS (LINE_WORDS),
    .TAG_W      (TAG_W)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .idx_i     (idx),
    .rd_off_i  (off),
    .wr_off_i  (cnt_q),
    .ctl_i     (ctl),
    .wr_tag_i  (tag),
    .wr_data_i (mem.mem_rdata),
    .valid_o   (line_valid),
    .tag_o     (line_tag),
    .data_o    (line_data)
  );

  // Next-state logic: accept, look up, refill, re-look up.
  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    cnt_d      = cnt_q;
    inv_pend_d = inv_pend_q;
    case (state_q)
      S_IDLE: begin
        if (fe.im_req) begin
          req_addr_d = fe.im_addr[ADDR_W-1:0];
          state_d    = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          if (fe.im_req) req_addr_d = fe.im_addr[ADDR_W-1:0];
          else           state_d    = S_IDLE;
        end else begin
          cnt_d      = '0;
          inv_pend_d = 1'b0;
          state_d    = S_REFILL;
        end
      end
      S_REFILL: begin
        // An invalidate mid-refill must keep this line from going valid.
        if (inv_i) inv_pend_d = 1'b1;
        if (mem.mem_ack) begin
          cnt_d = cnt_q + OFF_W'(1);
          if (cnt_q == LAST) state_d = S_LOOKUP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any refill in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      req_addr_q <= '0;
      cnt_q      <= '0;
      inv_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      cnt_q      <= cnt_d;
      inv_pend_q <= inv_pend_d;
    end
  end

endmodule

// File: tb/tb_sr_icache.sv
// Scoreboard bench for sr_icache: stimulus pushes expected fetch data and
// expected memory addresses, a monitor pops and compares on im_drdy/mem_ack.
module tb_sr_icache;
  import sr_icache_pkg::*;

  localparam int AW  = 30;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic inv = 1'b0;
  always #5 clk = ~clk;

  sr_icache_if         fe ();
  sr_mem_if #(.ADDR_W(AW)) mem ();

  sr_icache #(.ADDR_W(AW), .LINES(16), .LINE_WORDS(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .inv_i (inv),
    .fe    (fe),
    .mem   (mem)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acks_seen = 0;
  int last_ack_cyc = 0;
  int last_drdy_cyc = 0;
  bit stale_ack = 1'b0;
  logic [31:0]   exp_data_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [31:0]   av [0:3];

  always @(posedge clk) cyc <= cyc + 1;

  // Backing memory contents: word a holds {16'hC0DE, a[15:0]}.
  function automatic logic [31:0] memval(input logic [AW-1:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_line(input logic [AW-1:0] base);
    for (int k = 0; k < 4; k++) exp_addr_q.push_back(base + AW'(k));
  endtask

  // Memory responder: ack LAT cycles into each word; can inject one stale ack.
  initial begin
    int wt;
    wt = 0;
    mem.mem_ack   = 1'b0;
    mem.mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem.mem_ack = 1'b0;
      if (stale_ack) begin
        mem.mem_ack   = 1'b1;
        mem.mem_rdata = 32'hDEAD_BEEF;
        stale_ack     = 1'b0;
        wt            = 0;
      end else if (mem.mem_req) begin
        wt++;
        if (wt == LAT) begin
          mem.mem_ack   = 1'b1;
          mem.mem_rdata = memval(mem.mem_addr);
          wt            = 0;
        end
      end else begin
        wt = 0;
      end
    end
  end

  // Monitor: compare every accepted memory read and every delivered word.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem.mem_req && mem.mem_ack) begin
          acks_seen++;
          last_ack_cyc = cyc;
          if (exp_addr_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL mem_addr: unexpected read of %0h, none expected", mem.mem_addr);
          end else begin
            check("mem_addr", 64'(mem.mem_addr), 64'(exp_addr_q.pop_front()));
          end
        end
        if (fe.im_drdy) begin
          last_drdy_cyc = cyc;
          if (exp_data_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL im_data: unexpected drdy with %0h, none expected", fe.im_data);
          end else begin
            check("im_data", 64'(fe.im_data), 64'(exp_data_q.pop_front()));
          end
        end
      end
    end
  end

  // CPU model: issue a[0..n-1], moving to the next address on each drdy.
  task automatic run_fetch(input logic [31:0] a [0:3], input int n,
                           output int cycles, output int mreq);
    int i;
    int t;
    i = 0; t = 0; cycles = 0; mreq = 0;
    fe.im_addr = a[0];
    fe.im_req  = 1'b1;
    exp_data_q.push_back(memval(a[0][AW-1:0]));
    while (i < n) begin
      @(negedge clk);
      cycles++; t++;
      if (mem.mem_req) mreq++;
      if (fe.im_drdy) begin
        i++; t = 0;
        if (i < n) begin
          fe.im_addr = a[i];
          exp_data_q.push_back(memval(a[i][AW-1:0]));
        end else begin
          fe.im_req = 1'b0;
        end
      end else if (t > 300) begin
        checks++; errors++;
        $display("FAIL fetch_timeout: no drdy for addr %0h within 300 cycles", a[i]);
        fe.im_req = 1'b0;
        exp_data_q.delete();
        i = n;
      end
    end
  endtask

  task automatic drained(input string name);
    #1;
    check({name, "_addr_q"}, 64'(exp_addr_q.size()), 64'd0);
    check({name, "_data_q"}, 64'(exp_data_q.size()), 64'd0);
    exp_addr_q.delete();
    exp_data_q.delete();
  endtask

  task automatic pulse_inv();
    @(negedge clk); inv = 1'b1;
    @(negedge clk); inv = 1'b0;
  endtask

  initial begin
    int cy, mr, base, t;
    fe.im_req  = 1'b0;
    fe.im_addr = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_drdy",     64'(fe.im_drdy),    64'd0);
    check("rst_mem_req",  64'(mem.mem_req),   64'd0);
    check("rst_mem_addr", 64'(mem.mem_addr),  64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Cold miss on address 0 straight out of reset.
    push_line(AW'(0));
    av = '{32'd0, 32'd0, 32'd0, 32'd0};
    run_fetch(av, 1, cy, mr);
    #1;
    check("cold_drdy_after_ack", 64'(last_drdy_cyc - last_ack_cyc), 64'd1);
    drained("cold");

    // Sequential hits: three drdy cycles back to back, no memory traffic.
    av = '{32'd1, 32'd2, 32'd3, 32'd0};
    run_fetch(av, 3, cy, mr);
    check("seq_cycles",  64'(cy), 64'd3);
    check("seq_mem_req", 64'(mr), 64'd0);
    drained("seq");

    // Conflict miss: 0x40 evicts line 0, then 0 refills it again.
    push_line(AW'(32'h40));
    push_line(AW'(0));
    av = '{32'h40, 32'd0, 32'd0, 32'd0};
    run_fetch(av, 2, cy, mr);
    drained("conflict");

    // Invalidate: hits first, then inv, then a miss on word 1.
    av = '{32'd0, 32'd2, 32'd0, 32'd0};
    run_fetch(av, 2, cy, mr);
    check("inv_prehit_mem_req", 64'(mr), 64'd0);
    pulse_inv();
    push_line(AW'(0));
    av = '{32'd1, 32'd0, 32'd0, 32'd0};
    run_fetch(av, 1, cy, mr);
    drained("inv");

    // Invalidate during the second word of a refill forces a second refill.
    pulse_inv();
    push_line(AW'(0));
    push_line(AW'(0));
    base = acks_seen;
    av = '{32'd0, 32'd0, 32'd0, 32'd0};
    fork
      run_fetch(av, 1, cy, mr);
      begin
        t = 0;
        while (acks_seen < base + 1 && t < 300) begin @(negedge clk); t++; end
        @(posedge clk); #1; inv = 1'b1;
        @(posedge clk); #1; inv = 1'b0;
      end
    join
    drained("inv_refill");

    // Reset during the third word of a refill of 0x80.
    exp_addr_q.push_back(AW'(32'h80));
    exp_addr_q.push_back(AW'(32'h81));
    base = acks_seen;
    fe.im_addr = 32'h80;
    fe.im_req  = 1'b1;
    t = 0;
    while (acks_seen < base + 2 && t < 300) begin @(negedge clk); t++; end
    check("rst_mid_two_acks", 64'(acks_seen - base), 64'd2);
    @(posedge clk); #1;
    rst = 1'b1; fe.im_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_mem_req",  64'(mem.mem_req),  64'd0);
    check("rst_mid_drdy",     64'(fe.im_drdy),   64'd0);
    check("rst_mid_mem_addr", 64'(mem.mem_addr), 64'd0);
    stale_ack = 1'b1;
    @(negedge clk);
    check("stale_ack_mem_req", 64'(mem.mem_req), 64'd0);
    check("stale_ack_drdy",    64'(fe.im_drdy),  64'd0);
    @(negedge clk);
    drained("rst_mid");
    push_line(AW'(0));
    av = '{32'd0, 32'd0, 32'd0, 32'd0};
    run_fetch(av, 1, cy, mr);
    drained("post_rst");

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "watchdog");
  end

endmodule
